// File: rtl/ms_slave_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ms_slave_arbiter_if
// Purpose  : Bundle of requester-side and slave-side handshake signals for
//            ms_slave_arbiter. The "master" modport is the arbiter's view
//            (it masters the shared slave port); the "slave" modport is the
//            view of the surrounding requesters/consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface ms_slave_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_sync;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_notify;
    logic                      slv_notify;
    logic [DATA_W-1:0]         slv_data;
    logic                      slv_sync;
    logic [GW-1:0]             grant_id;
    logic [31:0]               xfer_cnt;

    modport master (
        input  req_sync, req_data, slv_sync,
        output req_notify, slv_notify, slv_data, grant_id, xfer_cnt
    );

    modport slave (
        output req_sync, req_data, slv_sync,
        input  req_notify, slv_notify, slv_data, grant_id, xfer_cnt
    );
endinterface
`default_nettype wire

// File: rtl/ms_slave_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ms_slave_arbiter
// Purpose  : Shares one blocking slave port among NUM_REQ requesters using
//            the sync/notify handshake. Latches the winner's word, presents
//            it to the slave, waits for slave sync, then pulses the winner's
//            notify. Round-robin by default.
// Options  : MS_ARB_FIXED_PRIO_EN - fixed priority (lowest index wins,
//            rotation pointer held at 0).
// Revision : 1.0 - initial release
// ============================================================================
module ms_slave_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    ms_slave_arbiter_if.master bus
);
    localparam int          GW    = $clog2(NUM_REQ);
    localparam int unsigned N_REQ = NUM_REQ;

    typedef enum logic [0:0] {
        SEC_IDLE = 1'b0,
        SEC_XFER = 1'b1
    } section_t;

    // section_q is the registered section; nextsection_d is its next value
    section_t            section_q, nextsection_d;
    logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]  req_notify_q, req_notify_d;
    logic                slv_notify_q, slv_notify_d;
    logic [DATA_W-1:0]   slv_data_q, slv_data_d;
    logic [GW-1:0]       grant_id_q, grant_id_d;
    logic [31:0]         xfer_cnt_q, xfer_cnt_d;

    logic [NUM_REQ-1:0]  eligible;
    logic                cand_valid;
    logic [GW-1:0]       cand_idx;

    // (base + off) mod NUM_REQ, valid for base < NUM_REQ and off < NUM_REQ
    function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base,
                                                input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return GW'(s);
    endfunction

    // Winner search: first eligible requester at or above the rotation
    // pointer, wrapping. A requester whose notify is high this cycle is
    // masked so the word it just handed over is not granted twice.
    always_comb begin
        eligible   = bus.req_sync & ~req_notify_q;
        cand_valid = 1'b0;
        cand_idx   = '0;
        // Walk offsets downward so the smallest offset is the final winner
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[wrap_add(rr_ptr_q, i)]) begin
                cand_valid = 1'b1;
                cand_idx   = wrap_add(rr_ptr_q, i);
            end
        end
    end

    // Next-section and datapath next-state logic
    always_comb begin
        nextsection_d = section_q;
        rr_ptr_d      = rr_ptr_q;
        req_notify_d  = '0;
        slv_notify_d  = slv_notify_q;
        slv_data_d    = slv_data_q;
        grant_id_d    = grant_id_q;
        xfer_cnt_d    = xfer_cnt_q;

        case (section_q)
            SEC_IDLE: begin
                if (cand_valid) begin
                    slv_data_d    = bus.req_data[cand_idx*DATA_W +: DATA_W];
                    grant_id_d    = cand_idx;
                    slv_notify_d  = 1'b1;
                    nextsection_d = SEC_XFER;
                end
            end
            SEC_XFER: begin
                // Payload is latched; requester inputs are ignored here
                if (bus.slv_sync) begin
                    slv_notify_d             = 1'b0;
                    req_notify_d[grant_id_q] = 1'b1;
                    xfer_cnt_d               = xfer_cnt_q + 32'd1;
`ifdef MS_ARB_FIXED_PRIO_EN
                    rr_ptr_d                 = '0;
`else
                    rr_ptr_d                 = wrap_add(grant_id_q, 1);
`endif
                    nextsection_d            = SEC_IDLE;
                end
            end
            default: begin
                nextsection_d = SEC_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            section_q    <= SEC_IDLE;
            rr_ptr_q     <= '0;
            req_notify_q <= '0;
            slv_notify_q <= 1'b0;
            slv_data_q   <= '0;
            grant_id_q   <= '0;
            xfer_cnt_q   <= '0;
        end else begin
            section_q    <= nextsection_d;
            rr_ptr_q     <= rr_ptr_d;
            req_notify_q <= req_notify_d;
            slv_notify_q <= slv_notify_d;
            slv_data_q   <= slv_data_d;
            grant_id_q   <= grant_id_d;
            xfer_cnt_q   <= xfer_cnt_d;
        end
    end

    assign bus.req_notify = req_notify_q;
    assign bus.slv_notify = slv_notify_q;
    assign bus.slv_data   = slv_data_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.xfer_cnt   = xfer_cnt_q;

endmodule
`default_nettype wire
